mem_arbiter: RTL and testbench

//  Shares the single-port unified memory between instruction fetch (F, read-only) and data (D, load/store).

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arb_picker.sv | 31 +++
 rtl/mem_arbiter.sv | 109 ++++++++++
 tb/tb_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, requester ids, latched request.
// Latency: n/a (types only).
// Backpressure: n/a. The struct widths below must equal the AWIDTH/DWIDTH of mem_arbiter.
package mem_arb_pkg;

   localparam int ARB_AW = 32;
   localparam int ARB_DW = 32;

   typedef enum logic {ST_IDLE, ST_ACCESS} arb_state_e;

   typedef enum logic {REQ_F, REQ_D} req_id_e;

   typedef struct packed {
      req_id_e            id;
      logic [ARB_AW-1:0]  addr;
      logic               we;
      logic [ARB_DW-1:0]  wdata;
      logic               err;
   } lat_req_t;

   // The requester that did not get the last grant.
   function automatic req_id_e other_req(input req_id_e id);
      return (id == REQ_D) ? REQ_F : REQ_D;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester (fetch/data), response and memory-side signals of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on requests only; responses and memory side have none.
interface mem_arbiter_if #(
   parameter int AWIDTH = 32,
   parameter int DWIDTH = 32
);
   logic              f_req_valid_i;
   logic              f_req_ready_o;
   logic [AWIDTH-1:0] f_req_addr_i;
   logic              d_req_valid_i;
   logic              d_req_ready_o;
   logic [AWIDTH-1:0] d_req_addr_i;
   logic              d_req_we_i;
   logic [DWIDTH-1:0] d_req_wdata_i;
   logic              f_rsp_valid_o;
   logic [DWIDTH-1:0] f_rsp_data_o;
   logic              f_rsp_err_o;
   logic              d_rsp_valid_o;
   logic [DWIDTH-1:0] d_rsp_data_o;
   logic              d_rsp_err_o;
   logic [AWIDTH-1:0] mem_addr_o;
   logic [DWIDTH-1:0] mem_data_o;
   logic              mem_read_en_o;
   logic              mem_write_en_o;
   logic [DWIDTH-1:0] mem_data_i;
   logic              mem_valid_i;

   // Arbiter side.
   modport slave (
      input  f_req_valid_i, f_req_addr_i, d_req_valid_i, d_req_addr_i, d_req_we_i, d_req_wdata_i,
      input  mem_data_i, mem_valid_i,
      output f_req_ready_o, d_req_ready_o,
      output f_rsp_valid_o, f_rsp_data_o, f_rsp_err_o, d_rsp_valid_o, d_rsp_data_o, d_rsp_err_o,
      output mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o
   );

   // Requesters plus memory, seen from outside the arbiter.
   modport master (
      output f_req_valid_i, f_req_addr_i, d_req_valid_i, d_req_addr_i, d_req_we_i, d_req_wdata_i,
      output mem_data_i, mem_valid_i,
      input  f_req_ready_o, d_req_ready_o,
      input  f_rsp_valid_o, f_rsp_data_o, f_rsp_err_o, d_rsp_valid_o, d_rsp_data_o, d_rsp_err_o,
      input  mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o
   );
endinterface

// File: rtl/mem_arb_picker.sv
// Combinational winner select between fetch and data requests (MEM_ARB_RR_EN: round-robin).
// Latency: 0 cycles, pure combinational.
// Backpressure: none; the caller gates ready with state and the winner's valid.
module mem_arb_picker
   import mem_arb_pkg::*;
(
   input  logic    i_f_vld,
   input  logic    i_d_vld,
   input  req_id_e i_last_grant,
   output req_id_e o_win
);

`ifdef MEM_ARB_RR_EN
   // A lone requester wins; on contention the one not granted last time wins.
   always_comb begin
      o_win = REQ_F;
      if (i_d_vld) o_win = REQ_D;
      if (i_f_vld && i_d_vld) o_win = other_req(i_last_grant);
   end
`else
   // Fixed priority: data beats fetch. Winner is irrelevant when nobody is valid.
   logic [1:0] w_unused_inputs;
   assign w_unused_inputs = {i_f_vld, i_last_grant};

   always_comb begin
      o_win = REQ_F;
      if (i_d_vld) o_win = REQ_D;
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares single-port memory between fetch and data requesters; MEM_ARB_RR_EN selects round-robin.
// Latency: request handshake in cycle N -> response strobe in cycle N+2; at most one access per 2 cycles.
// Backpressure: ready only in IDLE for the arbitration winner; responses cannot be stalled.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int                AWIDTH    = ARB_AW,
   parameter int                DWIDTH    = ARB_DW,
   parameter logic [AWIDTH-1:0] BASE_ADDR = AWIDTH'(32'h01000000),
   parameter int                MEM_DEPTH = 1024
)(
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  io_bus
);

   // One past the last valid byte address, kept one bit wider so the compare cannot wrap.
   localparam logic [AWIDTH:0] LIMIT = {1'b0, BASE_ADDR} + (AWIDTH+1)'(4 * MEM_DEPTH);

   arb_state_e        r_state;
   lat_req_t          r_lat;
   req_id_e           r_last_grant;
   req_id_e           w_win;
   logic              w_idle;
   logic              w_access;
   logic              w_hs;
   logic [AWIDTH-1:0] w_req_addr;
   logic              w_req_we;
   logic [DWIDTH-1:0] w_req_wdata;
   logic              w_req_err;
   logic              w_rsp_err;
   logic [DWIDTH-1:0] w_rsp_data;

   mem_arb_picker u_picker (
      .i_f_vld      (io_bus.f_req_valid_i),
      .i_d_vld      (io_bus.d_req_valid_i),
      .i_last_grant (r_last_grant),
      .o_win        (w_win)
   );

   assign w_idle   = (r_state == ST_IDLE);
   assign w_access = (r_state == ST_ACCESS);

   assign io_bus.f_req_ready_o = w_idle & io_bus.f_req_valid_i & (w_win == REQ_F);
   assign io_bus.d_req_ready_o = w_idle & io_bus.d_req_valid_i & (w_win == REQ_D);
   assign w_hs = io_bus.f_req_ready_o | io_bus.d_req_ready_o;

   // Request mux: fetch is always a read with no store data.
   assign w_req_addr  = (w_win == REQ_D) ? io_bus.d_req_addr_i : io_bus.f_req_addr_i;
   assign w_req_we    = (w_win == REQ_D) & io_bus.d_req_we_i;
   assign w_req_wdata = w_req_we ? io_bus.d_req_wdata_i : '0;
   assign w_req_err   = (w_req_addr[1:0] != 2'b00)
                      | ({1'b0, w_req_addr} <  {1'b0, BASE_ADDR})
                      | ({1'b0, w_req_addr} >= LIMIT);

   // Memory side is decoded from registered state so reset kills the enables at once.
   assign io_bus.mem_addr_o     = w_access ? r_lat.addr  : '0;
   assign io_bus.mem_data_o     = w_access ? r_lat.wdata : '0;
   assign io_bus.mem_read_en_o  = w_access & ~r_lat.err & ~r_lat.we;
   assign io_bus.mem_write_en_o = w_access & ~r_lat.err &  r_lat.we;

   // Loads fail when the memory reports invalid; stores and failed requests return zero data.
   assign w_rsp_err  = r_lat.err | (~r_lat.we & ~io_bus.mem_valid_i);
   assign w_rsp_data = (r_lat.we | w_rsp_err) ? '0 : io_bus.mem_data_i;

   // FSM: latch the granted request in IDLE, perform it in ACCESS, register the response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state              <= ST_IDLE;
         r_lat                <= '0;
         r_last_grant         <= REQ_F;
         io_bus.f_rsp_valid_o <= 1'b0;
         io_bus.f_rsp_data_o  <= '0;
         io_bus.f_rsp_err_o   <= 1'b0;
         io_bus.d_rsp_valid_o <= 1'b0;
         io_bus.d_rsp_data_o  <= '0;
         io_bus.d_rsp_err_o   <= 1'b0;
      end else begin
         io_bus.f_rsp_valid_o <= 1'b0;
         io_bus.f_rsp_err_o   <= 1'b0;
         io_bus.d_rsp_valid_o <= 1'b0;
         io_bus.d_rsp_err_o   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_hs) begin
                  r_lat        <= '{id: w_win, addr: w_req_addr, we: w_req_we,
                                    wdata: w_req_wdata, err: w_req_err};
                  r_last_grant <= w_win;
                  r_state      <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               r_state <= ST_IDLE;
               if (r_lat.id == REQ_D) begin
                  io_bus.d_rsp_valid_o <= 1'b1;
                  io_bus.d_rsp_data_o  <= w_rsp_data;
                  io_bus.d_rsp_err_o   <= w_rsp_err;
               end else begin
                  io_bus.f_rsp_valid_o <= 1'b1;
                  io_bus.f_rsp_data_o  <= w_rsp_data;
                  io_bus.f_rsp_err_o   <= w_rsp_err;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small zero-initialised memory model on the memory port.
// Vector table for single transactions, hand sequences for contention and reset mid-access.
// An invariant monitor runs alongside and is checked after every vector.
module tb_mem_arbiter;

   localparam logic [31:0] BASE = 32'h01000000;

   typedef struct {
      logic        is_d;
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic        mv;
      logic [31:0] exp_data;
      logic        exp_err;
      int          exp_rd;
      int          exp_wr;
   } vec_t;

   logic        clk;
   logic        rst;
   int          n_vec;
   int          n_miss;
   int          mon_viol;
   logic        prev_f_rsp;
   logic        prev_d_rsp;
   logic [31:0] mem_q [1024];
   logic [9:0]  w_idx;
   vec_t        vt [12];

   mem_arbiter_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

   mem_arbiter #(
      .AWIDTH    (32),
      .DWIDTH    (32),
      .BASE_ADDR (32'h01000000),
      .MEM_DEPTH (1024)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Memory model: combinational read, write on the rising edge.
   assign w_idx = 10'((bus.mem_addr_o - BASE) >> 2);
   assign bus.mem_data_i = bus.mem_read_en_o ? mem_q[w_idx] : 32'h0;

   initial begin
      for (int i = 0; i < 1024; i++) mem_q[i] = 32'h0;
   end

   always @(posedge clk) begin
      if (bus.mem_write_en_o) mem_q[w_idx] = bus.mem_data_o;
   end

   // Invariant monitor, sampled on the rising edge while inputs are stable.
   initial begin
      mon_viol = 0;
      prev_f_rsp = 1'b0;
      prev_d_rsp = 1'b0;
   end

   always @(posedge clk) begin
      if (!rst) begin
         if (bus.mem_read_en_o && bus.mem_write_en_o) mon_viol++;
         if (bus.f_rsp_valid_o && prev_f_rsp) mon_viol++;
         if (bus.d_rsp_valid_o && prev_d_rsp) mon_viol++;
         if ((bus.f_req_ready_o || bus.d_req_ready_o) && (bus.mem_read_en_o || bus.mem_write_en_o)) mon_viol++;
         if (bus.f_req_ready_o && bus.d_req_ready_o) mon_viol++;
         if (bus.f_req_ready_o && !bus.f_req_valid_i) mon_viol++;
         if (bus.d_req_ready_o && !bus.d_req_valid_i) mon_viol++;
      end
      prev_f_rsp = bus.f_rsp_valid_o;
      prev_d_rsp = bus.d_rsp_valid_o;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
      end
   endtask

   task automatic drop_reqs();
      bus.f_req_valid_i = 1'b0;
      bus.d_req_valid_i = 1'b0;
      bus.d_req_we_i    = 1'b0;
   endtask

   // One transaction from one requester; starts and ends just after a falling edge.
   task automatic run_vec(input int n, input vec_t v);
      logic        got_rdy;
      logic        got_err;
      logic        other;
      logic [31:0] got_data;
      int          lat;
      int          rdc;
      int          wrc;
      int          base;
      base = mon_viol;
      bus.mem_valid_i = v.mv;
      if (v.is_d) begin
         bus.d_req_valid_i = 1'b1;
         bus.d_req_addr_i  = v.addr;
         bus.d_req_we_i    = v.we;
         bus.d_req_wdata_i = v.wdata;
      end else begin
         bus.f_req_valid_i = 1'b1;
         bus.f_req_addr_i  = v.addr;
      end
      #1;
      got_rdy = 1'b0;
      for (int t = 0; t < 10; t++) begin
         if (v.is_d ? bus.d_req_ready_o : bus.f_req_ready_o) begin
            got_rdy = 1'b1;
            break;
         end
         @(negedge clk); #1;
      end
      chk($sformatf("v%0d_handshake", n), 32'(got_rdy), 32'd1);
      @(posedge clk);
      @(negedge clk); #1;
      drop_reqs();
      lat = -1; rdc = 0; wrc = 0;
      got_data = 32'hx; got_err = 1'bx; other = 1'bx;
      for (int k = 1; k <= 8; k++) begin
         if (k > 1) begin
            @(negedge clk); #1;
         end
         if (v.is_d ? bus.d_rsp_valid_o : bus.f_rsp_valid_o) begin
            lat      = k;
            got_data = v.is_d ? bus.d_rsp_data_o : bus.f_rsp_data_o;
            got_err  = v.is_d ? bus.d_rsp_err_o  : bus.f_rsp_err_o;
            other    = v.is_d ? bus.f_rsp_valid_o : bus.d_rsp_valid_o;
            break;
         end
         rdc += int'(bus.mem_read_en_o);
         wrc += int'(bus.mem_write_en_o);
      end
      chk($sformatf("v%0d_latency", n),   32'(lat),     32'd2);
      chk($sformatf("v%0d_data", n),      got_data,     v.exp_data);
      chk($sformatf("v%0d_err", n),       32'(got_err), 32'(v.exp_err));
      chk($sformatf("v%0d_other_rsp", n), 32'(other),   32'd0);
      chk($sformatf("v%0d_rd_cycles", n), 32'(rdc),     32'(v.exp_rd));
      chk($sformatf("v%0d_wr_cycles", n), 32'(wrc),     32'(v.exp_wr));
      chk($sformatf("v%0d_invariants", n), 32'(mon_viol - base), 32'd0);
      bus.mem_valid_i = 1'b1;
   endtask

   initial begin
      logic exp_g [4];
      int   n_g;
      logic got;
      logic gw;
      int   cnt;
      vec_t v;

      n_vec = 0; n_miss = 0;
      clk = 1'b0; rst = 1'b1;
      bus.f_req_valid_i = 1'b0; bus.f_req_addr_i = 32'h0;
      bus.d_req_valid_i = 1'b0; bus.d_req_addr_i = 32'h0;
      bus.d_req_we_i = 1'b0;    bus.d_req_wdata_i = 32'h0;
      bus.mem_valid_i = 1'b1;

      //         is_d  addr          we    wdata         mv    exp_data      err   rd wr
      vt[0]  = '{1'b1, 32'h01000000, 1'b1, 32'hdeadbeef, 1'b1, 32'h00000000, 1'b0, 0, 1};
      vt[1]  = '{1'b1, 32'h01000000, 1'b0, 32'h0,        1'b1, 32'hdeadbeef, 1'b0, 1, 0};
      vt[2]  = '{1'b1, 32'h01000002, 1'b0, 32'h0,        1'b1, 32'h00000000, 1'b1, 0, 0};
      vt[3]  = '{1'b1, 32'h01001000, 1'b1, 32'h00000055, 1'b1, 32'h00000000, 1'b1, 0, 0};
      vt[4]  = '{1'b0, 32'h00fffffc, 1'b0, 32'h0,        1'b1, 32'h00000000, 1'b1, 0, 0};
      vt[5]  = '{1'b0, 32'h01000000, 1'b0, 32'h0,        1'b1, 32'hdeadbeef, 1'b0, 1, 0};
      vt[6]  = '{1'b1, 32'h01000ffc, 1'b1, 32'ha5a50001, 1'b1, 32'h00000000, 1'b0, 0, 1};
      vt[7]  = '{1'b0, 32'h01000ffc, 1'b0, 32'h0,        1'b1, 32'ha5a50001, 1'b0, 1, 0};
      vt[8]  = '{1'b1, 32'h01000ffc, 1'b0, 32'h0,        1'b0, 32'h00000000, 1'b1, 1, 0};
      vt[9]  = '{1'b1, 32'hfffffffc, 1'b0, 32'h0,        1'b1, 32'h00000000, 1'b1, 0, 0};
      vt[10] = '{1'b1, 32'h01000ffc, 1'b0, 32'h0,        1'b1, 32'ha5a50001, 1'b0, 1, 0};
      vt[11] = '{1'b0, 32'h01000001, 1'b0, 32'h0,        1'b1, 32'h00000000, 1'b1, 0, 0};

      // Reset state.
      repeat (2) @(negedge clk);
      #1;
      chk("rst_f_rsp_valid", 32'(bus.f_rsp_valid_o),  32'd0);
      chk("rst_d_rsp_valid", 32'(bus.d_rsp_valid_o),  32'd0);
      chk("rst_f_rsp_data",  bus.f_rsp_data_o,        32'd0);
      chk("rst_d_rsp_data",  bus.d_rsp_data_o,        32'd0);
      chk("rst_d_rsp_err",   32'(bus.d_rsp_err_o),    32'd0);
      chk("rst_mem_rd",      32'(bus.mem_read_en_o),  32'd0);
      chk("rst_mem_wr",      32'(bus.mem_write_en_o), 32'd0);
      chk("rst_mem_addr",    bus.mem_addr_o,          32'd0);
      @(negedge clk); #1;
      rst = 1'b0;
      @(negedge clk); #1;

      for (int i = 0; i < 12; i++) run_vec(i, vt[i]);

      // Contention: both valid in the same cycle, starting from reset (last grant = fetch).
`ifdef MEM_ARB_RR_EN
      n_g = 4;
      exp_g[0] = 1'b1; exp_g[1] = 1'b0; exp_g[2] = 1'b1; exp_g[3] = 1'b0;
`else
      n_g = 2;
      exp_g[0] = 1'b1; exp_g[1] = 1'b0; exp_g[2] = 1'b1; exp_g[3] = 1'b1;
`endif
      rst = 1'b1;
      @(negedge clk); #1;
      rst = 1'b0;
      bus.f_req_valid_i = 1'b1; bus.f_req_addr_i = 32'h01000004;
      bus.d_req_valid_i = 1'b1; bus.d_req_addr_i = 32'h01000004; bus.d_req_we_i = 1'b0;
      #1;
      for (int g = 0; g < n_g; g++) begin
         got = 1'b0;
         for (int t = 0; t < 8; t++) begin
            if (bus.f_req_ready_o || bus.d_req_ready_o) begin
               got = 1'b1;
               break;
            end
            @(negedge clk); #1;
         end
         gw = bus.d_req_ready_o;
         chk($sformatf("dual%0d_handshake", g), 32'(got), 32'd1);
         chk($sformatf("dual%0d_both_ready", g), 32'(bus.f_req_ready_o & bus.d_req_ready_o), 32'd0);
         chk($sformatf("dual%0d_grant_is_d", g), 32'(gw), 32'(exp_g[g]));
         @(posedge clk);
         @(negedge clk); #1;
`ifndef MEM_ARB_RR_EN
         if (gw) bus.d_req_valid_i = 1'b0;
`endif
         if (g == n_g - 1) drop_reqs();
         @(negedge clk); #1;
         chk($sformatf("dual%0d_rsp_own", g),   32'(gw ? bus.d_rsp_valid_o : bus.f_rsp_valid_o), 32'd1);
         chk($sformatf("dual%0d_rsp_other", g), 32'(gw ? bus.f_rsp_valid_o : bus.d_rsp_valid_o), 32'd0);
      end
      drop_reqs();

      // Reset pulsed during the ACCESS cycle of a store.
      @(negedge clk); #1;
      bus.d_req_valid_i = 1'b1; bus.d_req_addr_i = 32'h01000008;
      bus.d_req_we_i = 1'b1;    bus.d_req_wdata_i = 32'h12345678;
      #1;
      got = 1'b0;
      for (int t = 0; t < 8; t++) begin
         if (bus.d_req_ready_o) begin
            got = 1'b1;
            break;
         end
         @(negedge clk); #1;
      end
      chk("rstmid_handshake", 32'(got), 32'd1);
      @(posedge clk);
      @(negedge clk); #1;
      chk("rstmid_we_before", 32'(bus.mem_write_en_o), 32'd1);
      rst = 1'b1;
      drop_reqs();
      #1;
      chk("rstmid_we_dropped", 32'(bus.mem_write_en_o), 32'd0);
      chk("rstmid_addr_zero",  bus.mem_addr_o,           32'd0);
      @(negedge clk); #1;
      rst = 1'b0;
      cnt = 0;
      for (int k = 0; k < 4; k++) begin
         cnt += int'(bus.d_rsp_valid_o) + int'(bus.f_rsp_valid_o);
         @(negedge clk); #1;
      end
      chk("rstmid_no_rsp", 32'(cnt), 32'd0);
      v = '{1'b1, 32'h01000008, 1'b0, 32'h0, 1'b1, 32'h00000000, 1'b0, 1, 0};
      run_vec(12, v);

      chk("invariants_total", 32'(mon_viol), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
